seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector, the parametrised successor to the fixed 11011 Mealy detector. It takes one bit per qualified clock and compares it against a run-time pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection. It produces a registered one-cycle match pulse and a saturating match counter. It sits on the serial data path next to the other stream monitors.

---
 rtl/seq_detect_prog.sv | 123 ++++++++++++
 tb/tb_seq_detect_prog.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_prog
// Description : Programmable serial bit-pattern detector. Compares a stream of
//               qualified bits against a run-time pattern of 1..MAX_LEN bits,
//               with overlapping or non-overlapping detection, and produces a
//               registered one-cycle match pulse plus a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    // Reset configuration reproduces the legacy 11011 detector.
    localparam logic [MAX_LEN-1:0] c_rst_pat = MAX_LEN'(5'b11011);
    localparam logic [LEN_W-1:0]   c_rst_len = LEN_W'(5);
    localparam logic [LEN_W-1:0]   c_max_len = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t               r_state;
    logic [MAX_LEN-1:0]   r_pat;
    logic [LEN_W-1:0]     r_len;
    logic                 r_ovl;
    // Only MAX_LEN-1 past bits are ever needed: the newest bit comes straight
    // from in_bit when the comparison window is formed.
    logic [MAX_LEN-2:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;

    logic [LEN_W-1:0]     w_cfg_len;
    logic [MAX_LEN-1:0]   w_window;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_ready;
    logic                 w_hit;
    logic [LEN_W-1:0]     w_fill_inc;
    logic [LEN_W-1:0]     w_fill_nxt;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    // Clamp the programmed length and evaluate the hit for the bit on in_bit.
    always_comb begin
        w_cfg_len = (cfg_len > c_max_len) ? c_max_len : cfg_len;
        w_window  = {r_hist, in_bit};
        // Shifting by MAX_LEN yields zero, so a full-length pattern gets an
        // all-ones mask.
        w_mask    = ~({MAX_LEN{1'b1}} << r_len);
        // Enough history exists once the new bit completes len bits.
        w_ready   = (r_state == ARMED) || (r_fill == r_len - LEN_W'(1));
        w_hit     = (r_len != '0) && w_ready &&
                    (((w_window ^ r_pat) & w_mask) == '0);

        w_fill_inc = (r_fill == r_len) ? r_fill : r_fill + LEN_W'(1);
        w_fill_nxt = (w_hit && !r_ovl) ? '0 : w_fill_inc;

        if (w_fill_nxt == '0) begin
            w_state_nxt = EMPTY;
        end else if (w_fill_nxt == r_len) begin
            w_state_nxt = ARMED;
        end else begin
            w_state_nxt = FILLING;
        end

        w_cnt_nxt = (&match_count) ? match_count : match_count + CNT_W'(1);
    end

    // Detector state machine with configuration, history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat       <= c_rst_pat;
            r_len       <= c_rst_len;
            r_ovl       <= 1'b1;
            r_hist      <= '0;
            r_fill      <= '0;
            r_state     <= EMPTY;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (cfg_we) begin
            // New configuration wins over a simultaneous data bit, which is dropped.
            r_pat       <= cfg_pattern;
            r_len       <= w_cfg_len;
            r_ovl       <= cfg_overlap;
            r_hist      <= '0;
            r_fill      <= '0;
            r_state     <= EMPTY;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (in_valid) begin
            r_hist  <= (w_hit && !r_ovl) ? '0 : w_window[MAX_LEN-2:0];
            r_fill  <= w_fill_nxt;
            r_state <= w_state_nxt;
            match   <= w_hit;
            if (w_hit) begin
                match_count <= w_cnt_nxt;
                count_sat   <= &w_cnt_nxt;
            end
        end else begin
            // Gaps are transparent: history holds, only the pulse drops.
            match <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_prog
// Description : Self-checking bench for seq_detect_prog. A queue-based model
//               of the received bit stream predicts match, match_count and
//               count_sat every cycle; directed scenarios pin the model with
//               hand-computed literals, then randomized traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    int vectors     = 0;
    int miscompares = 0;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (match),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // q holds the bits received since the last clear (oldest first); a hit is
    // simply "the last len bits equal the pattern, first bit = pat[len-1]".
    bit [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               q[$];
    int               m_cnt;
    bit               m_hit;
    bit               exp_match;
    bit               model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pat = 8'h1B; m_len = 5; m_ovl = 1'b1;
            q.delete(); exp_match = 1'b0; m_cnt = 0; model_ok = 1'b1;
        end else if (cfg_we) begin
            m_pat = cfg_pattern;
            m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_overlap;
            q.delete(); exp_match = 1'b0; m_cnt = 0;
        end else if (in_valid) begin
            q.push_back(in_bit);
            m_hit = (m_len > 0) && (q.size() >= m_len);
            if (m_hit)
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - 1 - i] != m_pat[i]) m_hit = 1'b0;
            exp_match = m_hit;
            if (m_hit) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) q.delete();
            end
            while (q.size() > MAX_LEN) void'(q.pop_front());
        end else begin
            exp_match = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            vectors += 3;
            if (match !== exp_match) begin
                miscompares++;
                $display("FAIL match: got %b expected %b at %0t", match, exp_match, $time);
            end
            if (match_count !== CNT_W'(m_cnt)) begin
                miscompares++;
                $display("FAIL match_count: got %0d expected %0d at %0t", match_count, m_cnt, $time);
            end
            if (count_sat !== (m_cnt == CNT_MAX)) begin
                miscompares++;
                $display("FAIL count_sat: got %b expected %b at %0t", count_sat, (m_cnt == CNT_MAX), $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change on the falling edge and are held for one full cycle.
    task automatic drive(input bit r, input bit we, input bit v, input bit b);
        rst = r; cfg_we = we; in_valid = v; in_bit = b;
        @(negedge clk);
    endtask

    task automatic configure(input bit [MAX_LEN-1:0] p, input int l, input bit o);
        cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
        // in_valid is high on purpose: the bit must be dropped.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    // Sends n bits MSB first; mv[k] is the match seen after the k-th bit.
    task automatic send(input bit [31:0] bits, input int n, output bit [31:0] mv);
        mv = '0;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b1, bits[n - 1 - k]);
            mv[k] = match;
        end
    endtask

    bit [31:0] mv;
    int        pulses;
    bit [4:0]  gap_bits;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        chk("reset_match", int'(match), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_sat", int'(count_sat), 0);

        // Legacy 11011, overlapping
        send(32'hDB7, 12, mv);
        chk("ovl_pulses", int'(mv[11:0]), 'h490);
        chk("ovl_count", int'(match_count), 3);

        // Same pattern, non-overlapping
        configure(8'h1B, 5, 1'b0);
        send(32'hDB7, 12, mv);
        chk("novl_pulses", int'(mv[11:0]), 'h410);
        chk("novl_count", int'(match_count), 2);

        // Gaps between bits are transparent
        drive(1'b1, 1'b0, 0, 0);
        pulses = 0;
        gap_bits = 5'b11011;
        for (int k = 0; k < 5; k++) begin
            int g = int'($urandom_range(1, 3));
            for (int j = 0; j < g; j++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1);
                pulses += int'(match);
            end
            drive(1'b0, 1'b0, 1'b1, gap_bits[4 - k]);
            pulses += int'(match);
            if (k == 4) chk("gap_match_5th", int'(match), 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pulses += int'(match);
        chk("gap_pulses", pulses, 1);

        // Reset mid-sequence discards the partial pattern
        drive(1'b1, 1'b0, 0, 0);
        send(32'b1101, 4, mv);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        send(32'b1, 1, mv);
        chk("rst_mid_nomatch", int'(mv[0]), 0);
        send(32'b11011, 5, mv);
        chk("rst_mid_pulses", int'(mv[4:0]), 'b10000);
        chk("rst_mid_count", int'(match_count), 1);

        // len=1 saturation
        configure(8'h01, 1, 1'b1);
        send(32'hFFFFF, 20, mv);
        chk("sat_pulses", int'(mv[19:0]), 'hFFFFF);
        chk("sat_count", int'(match_count), 15);
        chk("sat_flag", int'(count_sat), 1);

        // len=0 disables detection
        configure(8'h00, 0, 1'b1);
        send(32'h0000FFFF, 32, mv);
        chk("len0_pulses", int'(mv), 0);
        chk("len0_count", int'(match_count), 0);

        // len=12 clamps to 8
        configure(8'hA7, 12, 1'b1);
        send(32'hA7, 8, mv);
        chk("clamp_pulses", int'(mv[7:0]), 'h80);
        chk("clamp_count", int'(match_count), 1);

        // Randomized traffic checked every cycle by the model
        drive(1'b1, 1'b0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            bit r  = ($urandom % 200) == 0;
            bit we = ($urandom % 60) == 0;
            if (we) begin
                cfg_pattern = MAX_LEN'($urandom);
                cfg_len     = (($urandom % 4) == 0) ? LEN_W'($urandom_range(0, 15))
                                                    : LEN_W'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom);
            end
            drive(r, we, ($urandom % 4) != 0, 1'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
